// File: rtl/cmd_assembler.sv
// cmd_assembler: rebuilds the forward-link command bit stream from decoder TPP symbols,
// captures the 8-bit head, tracks the bit count against cmd_len and checks the frame CRC-16.
module cmd_assembler #(
  parameter int          BUF_W       = 64,
  parameter logic [15:0] CRC_RESIDUE = 16'h1D0F
) (
  input  logic             clk_1_92m,
  input  logic             rst_n,
  input  logic             tpp_clk,
  input  logic [1:0]       tpp_data,
  input  logic             delimiter,
  input  logic             dec_done,
  input  logic [7:0]       cmd_len,
  output logic [7:0]       cmd_head,
  output logic             head_finish,
  output logic             cmd_end,
  output logic [7:0]       bit_cnt,
  output logic [BUF_W-1:0] cmd_buf,
  output logic             crc_ok,
  output logic             frame_valid,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for a delimiter; outputs keep the last frame
  // HEAD  | collecting the first 8 bits
  // BODY  | collecting the rest, watching cmd_len and dec_done
  // DONE  | frame closed, outputs frozen until dec_done falls
  typedef enum logic [1:0] {IDLE, HEAD, BODY, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       tpp_sync_q, tpp_sync_d;
  logic [2:0]       del_sync_q, del_sync_d;
  logic [1:0]       done_sync_q, done_sync_d;
  logic             sym_stb_q, sym_stb_d;
  logic             del_stb_q, del_stb_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       cmd_head_q, cmd_head_d;
  logic             head_finish_q, head_finish_d;
  logic             cmd_end_q, cmd_end_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [BUF_W-1:0] cmd_buf_q, cmd_buf_d;
  logic             crc_ok_q, crc_ok_d;
  logic             frame_valid_q, frame_valid_d;
  logic             overflow_q, overflow_d;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    tpp_sync_d    = {tpp_sync_q[1:0], tpp_clk};
    del_sync_d    = {del_sync_q[1:0], delimiter};
    done_sync_d   = {done_sync_q[0], dec_done};
    sym_stb_d     = tpp_sync_q[1] & ~tpp_sync_q[2];
    del_stb_d     = del_sync_q[1] & ~del_sync_q[2];
    state_d       = state_q;
    crc_d         = crc_q;
    cmd_head_d    = cmd_head_q;
    head_finish_d = head_finish_q;
    cmd_end_d     = cmd_end_q;
    bit_cnt_d     = bit_cnt_q;
    cmd_buf_d     = cmd_buf_q;
    crc_ok_d      = crc_ok_q;
    frame_valid_d = 1'b0;
    overflow_d    = overflow_q;

    // A new delimiter always wins, including over a coincident symbol.
    if (del_stb_q) begin
      state_d       = HEAD;
      crc_d         = 16'hFFFF;
      cmd_head_d    = 8'd0;
      head_finish_d = 1'b0;
      cmd_end_d     = 1'b0;
      bit_cnt_d     = 8'd0;
      cmd_buf_d     = '0;
      crc_ok_d      = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      case (state_q)
        HEAD, BODY: begin
          if (sym_stb_q) begin
            cmd_buf_d = {cmd_buf_q[BUF_W-3:0], tpp_data};
            crc_d     = crc_step(crc_step(crc_q, tpp_data[1]), tpp_data[0]);
            if (bit_cnt_q >= 8'd254) begin
              bit_cnt_d  = 8'd255;
              overflow_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd2;
            end
          end
          if (state_q == HEAD) begin
            if (sym_stb_q && bit_cnt_d == 8'd8) begin
              cmd_head_d    = cmd_buf_d[7:0];
              head_finish_d = 1'b1;
              state_d       = BODY;
            end
          end else if (cmd_len != 8'd0 && bit_cnt_d >= cmd_len) begin
            // covers the exact hit, an odd length overshot by one, and a late cmd_len
            cmd_end_d = 1'b1;
          end
          if (done_sync_q[1]) begin
            state_d       = DONE;
            frame_valid_d = 1'b1;
            crc_ok_d      = (state_q == BODY) && (crc_d == CRC_RESIDUE);
          end
        end
        DONE: begin
          if (!done_sync_q[1]) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tpp_sync_q    <= 3'b000;
      del_sync_q    <= 3'b000;
      done_sync_q   <= 2'b00;
      sym_stb_q     <= 1'b0;
      del_stb_q     <= 1'b0;
      crc_q         <= 16'hFFFF;
      cmd_head_q    <= 8'd0;
      head_finish_q <= 1'b0;
      cmd_end_q     <= 1'b0;
      bit_cnt_q     <= 8'd0;
      cmd_buf_q     <= '0;
      crc_ok_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tpp_sync_q    <= tpp_sync_d;
      del_sync_q    <= del_sync_d;
      done_sync_q   <= done_sync_d;
      sym_stb_q     <= sym_stb_d;
      del_stb_q     <= del_stb_d;
      crc_q         <= crc_d;
      cmd_head_q    <= cmd_head_d;
      head_finish_q <= head_finish_d;
      cmd_end_q     <= cmd_end_d;
      bit_cnt_q     <= bit_cnt_d;
      cmd_buf_q     <= cmd_buf_d;
      crc_ok_q      <= crc_ok_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign cmd_head    = cmd_head_q;
  assign head_finish = head_finish_q;
  assign cmd_end     = cmd_end_q;
  assign bit_cnt     = bit_cnt_q;
  assign cmd_buf     = cmd_buf_q;
  assign crc_ok      = crc_ok_q;
  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Testbench for cmd_assembler: directed frame scenarios with random symbol payloads,
// compared against a bit-queue reference model of the received frame.
module tb_cmd_assembler;
  localparam int          BUF_W = 64;
  localparam logic [15:0] RES   = 16'h1D0F;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tpp_clk;
  logic [1:0]       tpp_data;
  logic             delimiter;
  logic             dec_done;
  logic [7:0]       cmd_len;
  logic [7:0]       cmd_head;
  logic             head_finish;
  logic             cmd_end;
  logic [7:0]       bit_cnt;
  logic [BUF_W-1:0] cmd_buf;
  logic             crc_ok;
  logic             frame_valid;
  logic             overflow;

  cmd_assembler #(.BUF_W(BUF_W), .CRC_RESIDUE(RES)) dut (
    .clk_1_92m(clk), .rst_n(rst_n), .tpp_clk(tpp_clk), .tpp_data(tpp_data),
    .delimiter(delimiter), .dec_done(dec_done), .cmd_len(cmd_len),
    .cmd_head(cmd_head), .head_finish(head_finish), .cmd_end(cmd_end),
    .bit_cnt(bit_cnt), .cmd_buf(cmd_buf), .crc_ok(crc_ok),
    .frame_valid(frame_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;

  always @(posedge clk) if (frame_valid) fv_count++;

  // reference model: received bits of the current frame, oldest first
  bit       bit_q[$];
  bit       tx_q[$];
  int       m_phase;  // 0 idle, 1 head, 2 body, 3 closed
  int       m_cnt;
  logic [7:0] m_head;
  logic     m_hf, m_end, m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [BUF_W-1:0] model_buf();
    logic [BUF_W-1:0] b = '0;
    for (int i = 0; i < BUF_W && i < bit_q.size(); i++) b[i] = bit_q[bit_q.size()-1-i];
    return b;
  endfunction

  function automatic logic [15:0] model_crc();
    logic [15:0] c = 16'hFFFF;
    foreach (bit_q[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ bit_q[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic model_clear();
    bit_q.delete();
    m_cnt = 0; m_head = 8'd0; m_hf = 1'b0; m_end = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic send_sym(input logic [1:0] d);
    tpp_data = d;
    tick(2);
    tpp_clk = 1'b1;
    tick(2);
    tpp_clk = 1'b0;
    tick(3);
    if (m_phase == 1 || m_phase == 2) begin
      bit_q.push_back(d[1]);
      bit_q.push_back(d[0]);
      if (m_cnt >= 254) begin m_cnt = 255; m_ovf = 1'b1; end
      else m_cnt = m_cnt + 2;
      if (m_phase == 1 && m_cnt == 8) begin
        for (int i = 0; i < 8; i++) m_head[i] = bit_q[bit_q.size()-1-i];
        m_hf = 1'b1;
        m_phase = 2;
      end else if (m_phase == 2 && cmd_len != 0 && m_cnt >= int'(cmd_len)) begin
        m_end = 1'b1;
      end
    end
  endtask

  task automatic send_del();
    delimiter = 1'b1;
    tick(2);
    delimiter = 1'b0;
    tick(4);
    model_clear();
    m_phase = 1;
  endtask

  task automatic set_len(input logic [7:0] v);
    cmd_len = v;
    tick(2);
    if (m_phase == 2 && v != 0 && m_cnt >= int'(v)) m_end = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"},  64'(bit_cnt),     64'(m_cnt[7:0]));
    chk({tag, "_head"}, 64'(cmd_head),    64'(m_head));
    chk({tag, "_hf"},   64'(head_finish), 64'(m_hf));
    chk({tag, "_end"},  64'(cmd_end),     64'(m_end));
    chk({tag, "_ovf"},  64'(overflow),    64'(m_ovf));
    chk({tag, "_buf"},  64'(cmd_buf),     64'(model_buf()));
  endtask

  task automatic close_frame(input string tag);
    int   lat = 0;
    logic exp_ok;
    exp_ok = (m_phase == 2) && (model_crc() == RES);
    dec_done = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (frame_valid) begin lat = k; break; end
    end
    chk({tag, "_fv_lat"}, 64'(lat), 64'd3);
    chk({tag, "_crc_ok"}, 64'(crc_ok), 64'(exp_ok));
    tick(1);
    chk({tag, "_fv_pulse"}, 64'(frame_valid), 64'd0);
    dec_done = 1'b0;
    tick(4);
    m_phase = 0;
    check_state({tag, "_held"});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_head"}, 64'(cmd_head), 64'd0);
    chk({tag, "_hf"},   64'(head_finish), 64'd0);
    chk({tag, "_end"},  64'(cmd_end), 64'd0);
    chk({tag, "_cnt"},  64'(bit_cnt), 64'd0);
    chk({tag, "_buf"},  64'(cmd_buf), 64'd0);
    chk({tag, "_crc"},  64'(crc_ok), 64'd0);
    chk({tag, "_fv"},   64'(frame_valid), 64'd0);
    chk({tag, "_ovf"},  64'(overflow), 64'd0);
  endtask

  task automatic send_tx(input logic [7:0] len_after_head);
    for (int i = 0; i + 1 < tx_q.size(); i += 2) begin
      send_sym({tx_q[i], tx_q[i+1]});
      if (i == 6) set_len(len_after_head);
    end
  endtask

  initial begin
    logic [15:0] c;
    int          fvb;
    rst_n = 1'b0; tpp_clk = 1'b0; tpp_data = 2'b00; delimiter = 1'b0;
    dec_done = 1'b0; cmd_len = 8'd0;
    m_phase = 0;
    model_clear();
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    send_sym(2'b11);
    check_state("idle_ignore");

    send_del();
    send_sym(2'b11); send_sym(2'b00); send_sym(2'b10); send_sym(2'b01);
    check_state("head");
    chk("head_c9", 64'(cmd_head), 64'h0C9);

    set_len(8'd24);
    for (int i = 0; i < 8; i++) begin
      send_sym(2'($urandom_range(0, 3)));
      check_state($sformatf("len24_s%0d", i));
    end
    chk("len24_end_final", 64'(cmd_end), 64'd1);
    fvb = fv_count;
    close_frame("len24");
    chk("len24_fv_once", 64'(fv_count), 64'(fvb + 1));

    // frame with a correct CRC appended in inverted form
    tx_q.delete();
    for (int i = 0; i < 32; i++) tx_q.push_back(1'($urandom_range(0, 1)));
    c = 16'hFFFF;
    foreach (tx_q[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ tx_q[i]) ? 16'h1021 : 16'h0000);
    for (int i = 15; i >= 0; i--) tx_q.push_back(~c[i]);
    set_len(8'd0);
    send_del();
    send_tx(8'd48);
    check_state("crc_good");
    close_frame("crc_good");
    chk("crc_good_ok", 64'(crc_ok), 64'd1);

    tx_q[20] = ~tx_q[20];
    set_len(8'd0);
    send_del();
    send_tx(8'd48);
    close_frame("crc_bad");
    chk("crc_bad_ok", 64'(crc_ok), 64'd0);

    // second delimiter at bit_cnt = 10
    set_len(8'd0);
    fvb = fv_count;
    send_del();
    for (int i = 0; i < 5; i++) send_sym(2'($urandom_range(0, 3)));
    chk("abort_cnt10", 64'(bit_cnt), 64'd10);
    send_del();
    for (int i = 0; i < 4; i++) send_sym(2'($urandom_range(0, 3)));
    check_state("restart");
    chk("abort_no_fv", 64'(fv_count), 64'(fvb));
    close_frame("restart");
    chk("restart_fv_one", 64'(fv_count), 64'(fvb + 1));

    // odd length overshoot
    send_del();
    for (int i = 0; i < 4; i++) send_sym(2'($urandom_range(0, 3)));
    set_len(8'd13);
    for (int i = 0; i < 3; i++) begin
      send_sym(2'($urandom_range(0, 3)));
      check_state($sformatf("odd13_s%0d", i));
    end
    close_frame("odd13");

    // cmd_len arriving after the count already passed it
    set_len(8'd0);
    send_del();
    for (int i = 0; i < 8; i++) send_sym(2'($urandom_range(0, 3)));
    chk("late_len_before", 64'(cmd_end), 64'd0);
    set_len(8'd12);
    check_state("late_len");
    close_frame("late_len");

    // asynchronous reset mid-BODY
    set_len(8'd0);
    send_del();
    for (int i = 0; i < 10; i++) send_sym(2'($urandom_range(0, 3)));
    chk("rst_mid_cnt20", 64'(bit_cnt), 64'd20);
    #3 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    tick(2);
    rst_n = 1'b1;
    m_phase = 0;
    model_clear();
    tick(2);
    send_sym(2'b10); send_sym(2'b01);
    check_state("rst_ignore");

    // saturation with unknown length
    send_del();
    for (int i = 0; i < 130; i++) send_sym(2'($urandom_range(0, 3)));
    check_state("sat");
    chk("sat_cnt", 64'(bit_cnt), 64'd255);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_end", 64'(cmd_end), 64'd0);
    close_frame("sat");

    // dec_done while still in HEAD
    send_del();
    send_sym(2'b11); send_sym(2'b11);
    close_frame("early_done");
    chk("early_done_hf", 64'(head_finish), 64'd0);
    chk("early_done_crc", 64'(crc_ok), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
